// File: rtl/adder60_fault_checker.sv
// rtl/adder60_fault_checker.sv - dual-rail/parity checker stage for the duplicated 60-bit adder
// Two-stage valid/ready pipeline with error statistics and OK/DEGRADED/ALARM health FSM.
module adder60_fault_checker #(
    parameter int WIDTH      = 60,
    parameter int CNT_W      = 16,
    parameter int CONSEC_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] s_invert,
    input  logic             papb,
    input  logic             pab,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_papb,
    output logic [1:0]       out_err,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state,
    input  logic             clr_alarm
);

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_DEGRADED = 2'b01,
        ST_ALARM    = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CONSEC_LIM = CNT_W'(CONSEC_MAX);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_s;
    logic [WIDTH-1:0] s1_s_invert;
    logic             s1_papb;
    logic             s1_pab;
    logic             adv2;
    logic             xfer;
    logic             faulty;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] consec_q, consec_d, consec_inc;

    assign adv2     = !out_valid || out_ready;
    assign in_ready = !s1_valid || adv2;
    assign xfer     = out_valid && out_ready;
    assign faulty   = |out_err;

    // Stage 1: raw capture of the adder's dual-rail result
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_s        <= '0;
            s1_s_invert <= '0;
            s1_papb     <= 1'b0;
            s1_pab      <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1_valid    <= 1'b1;
            s1_s        <= s;
            s1_s_invert <= s_invert;
            s1_papb     <= papb;
            s1_pab      <= pab;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: checks computed on the way in, held stable while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_papb  <= 1'b0;
            out_err   <= 2'b00;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum  <= s1_s;
                out_papb <= s1_papb;
                out_err  <= {(^s1_s) ^ s1_pab, |(s1_s ^ ~s1_s_invert)};
            end
        end
    end

    assign consec_inc = (consec_q == CNT_MAX) ? consec_q : consec_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        err_count_d = err_count_q;
        consec_d    = consec_q;
        if (clr_alarm) begin
            state_d     = ST_OK;
            err_count_d = '0;
            consec_d    = '0;
        end else if (xfer) begin
            if (faulty) begin
                err_count_d = (err_count_q == CNT_MAX) ? err_count_q : err_count_q + 1'b1;
                consec_d    = consec_inc;
                if (consec_inc >= CONSEC_LIM) begin
                    state_d = ST_ALARM;
                end else if (state_q == ST_OK) begin
                    state_d = ST_DEGRADED;
                end
            end else begin
                consec_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_OK;
            err_count_q <= '0;
            consec_q    <= '0;
        end else begin
            state_q     <= state_d;
            err_count_q <= err_count_d;
            consec_q    <= consec_d;
        end
    end

    assign state     = state_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_adder60_fault_checker.sv
// tb/tb_adder60_fault_checker.sv - randomized scoreboard bench for adder60_fault_checker
module tb_adder60_fault_checker;

    localparam int CONSEC_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        clr_alarm = 1'b0;
    logic        papb = 1'b0;
    logic        pab = 1'b0;
    logic [59:0] s = '0;
    logic [59:0] s_invert = '0;

    logic        in_ready, out_valid, out_papb;
    logic [59:0] out_sum;
    logic [1:0]  out_err, state;
    logic [15:0] err_count;

    logic        in_ready_sm, out_valid_sm, out_papb_sm;
    logic [59:0] out_sum_sm;
    logic [1:0]  out_err_sm, state_sm;
    logic [3:0]  err_count_sm;

    adder60_fault_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .s_invert(s_invert), .papb(papb), .pab(pab),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_papb(out_papb), .out_err(out_err), .err_count(err_count),
        .state(state), .clr_alarm(clr_alarm)
    );

    adder60_fault_checker #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_sm),
        .s(s), .s_invert(s_invert), .papb(papb), .pab(pab),
        .out_valid(out_valid_sm), .out_ready(out_ready), .out_sum(out_sum_sm),
        .out_papb(out_papb_sm), .out_err(out_err_sm), .err_count(err_count_sm),
        .state(state_sm), .clr_alarm(clr_alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [59:0] sum;
        logic        papb;
        logic [1:0]  err;
        int          age;
    } item_t;

    item_t q[$];
    int    m_err, m_err_small, m_consec, m_state, m_out_count;
    int    checks = 0;
    int    errors = 0;
    bit    accepted;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [59:0] rnd60();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[59:0];
    endfunction

    task automatic clear_stats();
        m_err       = 0;
        m_err_small = 0;
        m_consec    = 0;
        m_state     = 0;
    endtask

    // One clock: observe handshake at negedge, advance the model, check stats after the edge
    task automatic cycle();
        bit    exp_ready, exp_valid, xfer;
        item_t it;
        @(negedge clk);
        accepted = 0;
        if (!rst) begin
            exp_ready = !(q.size() == 2 && !out_ready);
            exp_valid = q.size() > 0 && q[0].age >= 2;
            check("in_ready", 64'(in_ready), 64'(exp_ready));
            check("out_valid", 64'(out_valid), 64'(exp_valid));
            xfer = exp_valid && out_ready;
            if (exp_valid) begin
                check("out_sum", 64'(out_sum), 64'(q[0].sum));
                check("out_papb", 64'(out_papb), 64'(q[0].papb));
                check("out_err", 64'(out_err), 64'(q[0].err));
            end
            if (clr_alarm) begin
                clear_stats();
            end else if (xfer) begin
                if (q[0].err != 2'b00) begin
                    m_err       = (m_err == 65535) ? m_err : m_err + 1;
                    m_err_small = (m_err_small == 15) ? m_err_small : m_err_small + 1;
                    m_consec    = m_consec + 1;
                    if (m_consec >= CONSEC_MAX) m_state = 2;
                    else if (m_state == 0) m_state = 1;
                end else begin
                    m_consec = 0;
                end
            end
            if (xfer) begin
                void'(q.pop_front());
                m_out_count++;
            end
            if (in_valid && exp_ready) begin
                it.sum  = s;
                it.papb = papb;
                it.err  = {((^s) != pab), (s != ~s_invert)};
                it.age  = 0;
                q.push_back(it);
                accepted = 1;
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            clear_stats();
        end
        foreach (q[i]) q[i].age++;
        check("err_count", 64'(err_count), 64'(m_err));
        check("state", 64'(state), 64'(m_state));
        check("err_count_small", 64'(err_count_sm), 64'(m_err_small));
        check("state_small", 64'(state_sm), 64'(m_state));
    endtask

    task automatic send(input logic [59:0] sv, input logic [59:0] siv, input logic pv, input logic papv);
        s        = sv;
        s_invert = siv;
        pab      = pv;
        papb     = papv;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            cycle();
            if (accepted) break;
        end
        if (!accepted) check("send_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic send_good(input logic [59:0] x);
        send(x, ~x, ^x, 1'($urandom_range(0, 1)));
    endtask

    task automatic send_par_fault(input logic [59:0] x);
        send(x, ~x, ~(^x), 1'($urandom_range(0, 1)));
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse_clr();
        clr_alarm = 1'b1;
        cycle();
        clr_alarm = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt, budget;
        logic [59:0] x;
        clear_stats();
        m_out_count = 0;

        rst = 1'b1;
        idle(2);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_sum", 64'(out_sum), 64'(0));
        check("rst_out_papb", 64'(out_papb), 64'(0));
        check("rst_out_err", 64'(out_err), 64'(0));
        check("rst_err_count", 64'(err_count), 64'(0));
        check("rst_state", 64'(state), 64'(0));
        rst = 1'b0;

        // Clean result, two-cycle latency
        send_good(60'h123);
        cycle();
        check("t1_valid", 64'(out_valid), 64'(1));
        check("t1_sum", 64'(out_sum), 64'(60'h123));
        check("t1_err", 64'(out_err), 64'(0));
        cycle();
        check("t1_state", 64'(state), 64'(0));
        check("t1_count", 64'(err_count), 64'(0));

        // Duplication fault on bit 1
        send(60'h1, ~60'h3, 1'b1, 1'b0);
        cycle();
        check("t2_err", 64'(out_err), 64'(2'b01));
        cycle();
        check("t2_count", 64'(err_count), 64'(1));
        check("t2_state", 64'(state), 64'(1));

        // Four parity faults in a row reach ALARM, which is sticky until cleared
        pulse_clr();
        for (int i = 0; i < 4; i++) send_par_fault(rnd60());
        idle(3);
        check("t3_count", 64'(err_count), 64'(4));
        check("t3_alarm", 64'(state), 64'(2));
        send_good(rnd60());
        idle(3);
        check("t3_sticky", 64'(state), 64'(2));
        pulse_clr();
        check("t3_clr_state", 64'(state), 64'(0));
        check("t3_clr_count", 64'(err_count), 64'(0));

        // Random clean stream under random backpressure
        m_out_count = 0;
        acc_cnt = 0;
        budget = 0;
        while (acc_cnt < 1000 && budget < 20000) begin
            x         = rnd60();
            s         = x;
            s_invert  = ~x;
            pab       = ^x;
            papb      = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
            if (accepted) acc_cnt++;
            budget++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(4);
        check("t4_accepted", 64'(acc_cnt), 64'(1000));
        check("t4_emitted", 64'(m_out_count), 64'(1000));
        check("t4_drained", 64'(q.size()), 64'(0));

        // Mixed faults, stalls and occasional clears
        for (int i = 0; i < 400; i++) begin
            x         = rnd60();
            s         = x;
            s_invert  = ($urandom_range(0, 5) == 0) ? (~x ^ (60'h1 << $urandom_range(0, 59))) : ~x;
            pab       = ($urandom_range(0, 4) == 0) ? ~(^x) : ^x;
            papb      = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_alarm = ($urandom_range(0, 40) == 0);
            cycle();
        end
        in_valid = 1'b0;
        clr_alarm = 1'b0;
        out_ready = 1'b1;
        idle(4);

        // Saturation of the narrow counter
        pulse_clr();
        for (int i = 0; i < 19; i++) send(60'h5, ~60'h7, ^60'h5, 1'b0);
        idle(3);
        check("t5_small_sat", 64'(err_count_sm), 64'(4'hF));
        check("t5_wide_count", 64'(err_count), 64'(19));

        // clr_alarm coinciding with a faulty transfer
        pulse_clr();
        send_par_fault(rnd60());
        idle(3);
        out_ready = 1'b0;
        send_par_fault(rnd60());
        idle(2);
        check("t6_stalled_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b1;
        clr_alarm = 1'b1;
        cycle();
        clr_alarm = 1'b0;
        check("t6_clr_count", 64'(err_count), 64'(0));
        check("t6_clr_state", 64'(state), 64'(0));

        // Reset with two results in flight
        out_ready = 1'b0;
        send_good(rnd60());
        send_good(rnd60());
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t6_rst_valid", 64'(out_valid), 64'(0));
        check("t6_rst_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        idle(5);
        check("t6_nothing_left", 64'(out_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
